// File: rtl/pu_pkg.sv
// Shared constants, widths helper and saturating add for the MAC pipeline.
// Imported by pu_mac_pipe and pu_adder_tree.
package pu_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned IN_W_DEF  = 5;
  localparam int unsigned W_W_DEF   = 5;
  localparam int unsigned ACC_W_DEF = 16;

  // Working width for the saturating add; the accumulator must stay well inside it.
  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] value;
    logic             ovf;
  } sat_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // a and b arrive already sign/zero-extended to SAT_W; result is clamped to a w-bit range.
  function automatic sat_t sat_add(input logic [SAT_W-1:0] a,
                                   input logic [SAT_W-1:0] b,
                                   input int unsigned      w,
                                   input bit               sgn);
    logic [SAT_W-1:0] sum;
    logic [SAT_W-1:0] max_v;
    logic [SAT_W-1:0] min_v;
    sat_t             r;
    sum     = a + b;
    max_v   = '0;
    min_v   = '0;
    r.value = sum;
    r.ovf   = 1'b0;
    if (sgn) begin
      max_v = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
      min_v = ~max_v;
      if ($signed(sum) > $signed(max_v)) begin
        r.value = max_v;
        r.ovf   = 1'b1;
      end else if ($signed(sum) < $signed(min_v)) begin
        r.value = min_v;
        r.ovf   = 1'b1;
      end
    end else begin
      max_v = (SAT_W'(1) << w) - SAT_W'(1);
      if (sum > max_v) begin
        r.value = max_v;
        r.ovf   = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pu_adder_tree.sv
// Combinational balanced adder tree over LANES products; operands are widened
// to the full sum width at the leaves so no internal node can overflow.
module pu_adder_tree
  import pu_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned PROD_W = IN_W_DEF + W_W_DEF,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned SUM_W = PROD_W + clog2(LANES)
) (
  input  logic [LANES*PROD_W-1:0] prods,
  output logic [SUM_W-1:0]        sum
);

  // Heap-indexed tree: node k sums children 2k and 2k+1, leaves at LANES..2*LANES-1.
  logic [SUM_W-1:0] node [1:2*LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    if (SIGNED) begin : g_s
      assign node[LANES+i] = SUM_W'($signed(prods[i*PROD_W +: PROD_W]));
    end else begin : g_u
      assign node[LANES+i] = SUM_W'(prods[i*PROD_W +: PROD_W]);
    end
  end

  for (genvar k = 1; k < LANES; k++) begin : g_node
    assign node[k] = node[2*k] + node[2*k+1];
  end

  assign sum = node[1];

endmodule

// File: rtl/pu_mac_pipe.sv
// Three-stage multiply / adder-tree / windowed saturating accumulator with
// valid/last framing; one window result pulse per closing beat.
module pu_mac_pipe
  import pu_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned W_W    = W_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic [LANES*W_W-1:0]  weight,
  output logic                  out_valid,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_sat
);

  localparam int unsigned PROD_W = IN_W + W_W;
  localparam int unsigned SUM_W  = PROD_W + clog2(LANES);

  if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("pu_mac_pipe: LANES must be a power of two and at least 2");
  end
  if (ACC_W < SUM_W || ACC_W > SAT_W - 2) begin : g_bad_acc
    $error("pu_mac_pipe: ACC_W must cover the tree sum and fit the saturating adder");
  end

  logic [LANES*PROD_W-1:0] prod_c;
  logic [LANES*PROD_W-1:0] prod_q;
  logic [SUM_W-1:0]        sum_c;
  logic [SUM_W-1:0]        sum_q;
  logic                    v1_q, l1_q, v2_q, l2_q;
  logic [ACC_W-1:0]        acc_q;
  logic                    sticky_q;

  // Lane multipliers: operands widened to the product width first, so the low
  // PROD_W bits of the product are exact in both signed and unsigned mode.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    if (SIGNED) begin : g_s
      assign a_ext = PROD_W'($signed(in_data[i*IN_W +: IN_W]));
      assign b_ext = PROD_W'($signed(weight[i*W_W +: W_W]));
    end else begin : g_u
      assign a_ext = PROD_W'(in_data[i*IN_W +: IN_W]);
      assign b_ext = PROD_W'(weight[i*W_W +: W_W]);
    end
    assign prod_c[i*PROD_W +: PROD_W] = a_ext * b_ext;
  end

  pu_adder_tree #(
    .LANES  (LANES),
    .PROD_W (PROD_W),
    .SIGNED (SIGNED)
  ) u_tree (
    .prods (prod_q),
    .sum   (sum_c)
  );

  // Stage-3 candidate: accumulator plus the current tree sum, clamped to ACC_W.
  logic [SAT_W-1:0] acc_wide_c;
  logic [SAT_W-1:0] sum_wide_c;
  sat_t             res_c;
  logic [ACC_W-1:0] next_c;
  logic             ovf_c;

  always_comb begin
    acc_wide_c = SAT_W'(acc_q);
    sum_wide_c = SAT_W'(sum_q);
    if (SIGNED) begin
      acc_wide_c = SAT_W'($signed(acc_q));
      sum_wide_c = SAT_W'($signed(sum_q));
    end
    res_c  = sat_add(acc_wide_c, sum_wide_c, ACC_W, SIGNED);
    next_c = ACC_W'(res_c.value);
    ovf_c  = res_c.ovf;
  end

  // Datapath registers; their contents are ignored whenever the matching valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      sum_q  <= '0;
    end else begin
      prod_q <= prod_c;
      sum_q  <= sum_c;
    end
  end

  // Control, accumulator and result registers; clear flushes in-flight beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      v2_q      <= 1'b0;
      l2_q      <= 1'b0;
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      v2_q      <= 1'b0;
      l2_q      <= 1'b0;
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1_q      <= in_valid;
      l1_q      <= in_valid & in_last;
      v2_q      <= v1_q;
      l2_q      <= l1_q;
      out_valid <= 1'b0;
      if (v2_q) begin
        if (l2_q) begin
          out_data  <= next_c;
          out_sat   <= sticky_q | ovf_c;
          out_valid <= 1'b1;
          acc_q     <= '0;
          sticky_q  <= 1'b0;
        end else begin
          acc_q    <= next_c;
          sticky_q <= sticky_q | ovf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_pu_mac_pipe.sv
// Scoreboard bench: one stimulus stream drives three configurations
// (unsigned/16, unsigned/12, signed/16); a behavioural model predicts each window.
`timescale 1ns/1ps
module tb_pu_mac_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned IN_W  = 5;
  localparam int unsigned W_W   = 5;
  localparam int unsigned NDUT  = 3;

  typedef struct {
    int          cyc;
    logic [19:0] d;
    logic [19:0] w;
    bit          last;
  } beat_t;

  typedef struct {
    int     due;
    longint data;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst, clear, in_valid, in_last;
  logic [LANES*IN_W-1:0] in_data;
  logic [LANES*W_W-1:0]  weight;
  logic        ov0, ov1, ov2, os0, os1, os2;
  logic [15:0] od0;
  logic [11:0] od1;
  logic [15:0] od2;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int unsigned acc_w  [NDUT] = '{16, 12, 16};
  bit          is_sgn [NDUT] = '{1'b0, 1'b0, 1'b1};
  longint      acc    [NDUT];
  bit          sticky [NDUT];
  longint      held_d [NDUT];
  bit          held_s [NDUT];
  beat_t       pend[$];
  exp_t        exp_q [NDUT][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pu_mac_pipe u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .weight(weight), .out_valid(ov0), .out_data(od0), .out_sat(os0));

  pu_mac_pipe #(.ACC_W(12)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .weight(weight), .out_valid(ov1), .out_data(od1), .out_sat(os1));

  pu_mac_pipe #(.SIGNED(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .weight(weight), .out_valid(ov2), .out_data(od2), .out_sat(os2));

  task automatic check(input string tag, input longint got, input longint expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic longint fld(input logic [IN_W-1:0] v, input bit s);
    if (s) return longint'($signed(v));
    return longint'(v);
  endfunction

  function automatic logic [19:0] lanes(input int a3, input int a2, input int a1, input int a0);
    return {IN_W'(a3), IN_W'(a2), IN_W'(a1), IN_W'(a0)};
  endfunction

  // Apply one beat to every configuration's reference accumulator.
  task automatic retire_beat(input beat_t b);
    for (int j = 0; j < NDUT; j++) begin
      longint s, nxt, hi, lo, one;
      bit     ovf;
      exp_t   e;
      logic [IN_W-1:0] dv, wv;
      one = 1;
      s   = 0;
      for (int i = 0; i < LANES; i++) begin
        dv = b.d[i*IN_W +: IN_W];
        wv = b.w[i*W_W +: W_W];
        s += fld(dv, is_sgn[j]) * fld(wv, is_sgn[j]);
      end
      if (is_sgn[j]) begin
        hi = (one << (acc_w[j] - 1)) - 1;
        lo = -(one << (acc_w[j] - 1));
      end else begin
        hi = (one << acc_w[j]) - 1;
        lo = 0;
      end
      nxt = acc[j] + s;
      ovf = 1'b0;
      if (nxt > hi) begin
        nxt = hi; ovf = 1'b1;
      end else if (nxt < lo) begin
        nxt = lo; ovf = 1'b1;
      end
      if (b.last) begin
        e.due  = b.cyc + 3;
        e.data = nxt & ((one << acc_w[j]) - 1);
        e.sat  = sticky[j] | ovf;
        exp_q[j].push_back(e);
        acc[j]    = 0;
        sticky[j] = 1'b0;
      end else begin
        acc[j]    = nxt;
        sticky[j] = sticky[j] | ovf;
      end
    end
  endtask

  // Called just after a rising edge; a beat reaches the accumulator 3 calls later,
  // and a clear wipes the beats of this cycle and the two before it.
  task automatic drive(input bit v, input bit l, input bit c,
                       input logic [19:0] d, input logic [19:0] w);
    beat_t b;
    while (pend.size() > 0 && pend[0].cyc <= cyc - 3) retire_beat(pend.pop_front());
    if (c) begin
      pend.delete();
      for (int j = 0; j < NDUT; j++) begin
        acc[j]    = 0;
        sticky[j] = 1'b0;
      end
    end else if (v) begin
      b.cyc  = cyc;
      b.d    = d;
      b.w    = w;
      b.last = l;
      pend.push_back(b);
    end
    in_valid = v;
    in_last  = l;
    clear    = c;
    in_data  = d;
    weight   = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 20'd0, 20'd0);
  endtask

  task automatic pulse_reset();
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    clear    = 1'b0;
    pend.delete();
    for (int j = 0; j < NDUT; j++) begin
      acc[j]    = 0;
      sticky[j] = 1'b0;
      held_d[j] = 0;
      held_s[j] = 1'b0;
      exp_q[j].delete();
    end
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pulses are matched against the scoreboard, quiet cycles must hold.
  always @(negedge clk) begin
    logic   ovv [NDUT];
    longint odv [NDUT];
    logic   osv [NDUT];
    exp_t   e;
    ovv[0] = ov0; ovv[1] = ov1; ovv[2] = ov2;
    odv[0] = longint'(od0); odv[1] = longint'(od1); odv[2] = longint'(od2);
    osv[0] = os0; osv[1] = os1; osv[2] = os2;
    for (int j = 0; j < NDUT; j++) begin
      if (ovv[j] === 1'b1) begin
        if (exp_q[j].size() == 0) begin
          check($sformatf("d%0d_unexpected_valid", j), 1, 0);
        end else begin
          e = exp_q[j].pop_front();
          check($sformatf("d%0d_latency", j), cyc, e.due);
          check($sformatf("d%0d_data", j), odv[j], e.data);
          check($sformatf("d%0d_sat", j), longint'(osv[j]), longint'(e.sat));
          held_d[j] = e.data;
          held_s[j] = e.sat;
        end
      end else begin
        if (ovv[j] !== 1'b0) check($sformatf("d%0d_valid_x", j), 1, 0);
        if (exp_q[j].size() > 0 && exp_q[j][0].due <= cyc) begin
          e = exp_q[j].pop_front();
          check($sformatf("d%0d_missing_valid", j), 0, 1);
          held_d[j] = e.data;
          held_s[j] = e.sat;
        end
        check($sformatf("d%0d_hold_data", j), odv[j], held_d[j]);
        check($sformatf("d%0d_hold_sat", j), longint'(osv[j]), longint'(held_s[j]));
      end
    end
  end

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; weight = '0;
    for (int j = 0; j < NDUT; j++) begin
      acc[j] = 0; sticky[j] = 1'b0; held_d[j] = 0; held_s[j] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    idle(2);

    // Single-beat window of full-scale operands
    drive(1, 1, 0, lanes(31, 31, 31, 31), lanes(31, 31, 31, 31));
    idle(5);

    // Three beats with two bubbles after the first
    drive(1, 0, 0, lanes(4, 3, 2, 1), lanes(1, 1, 1, 1));
    idle(2);
    drive(1, 0, 0, lanes(4, 3, 2, 1), lanes(1, 1, 1, 1));
    drive(1, 1, 0, lanes(4, 3, 2, 1), lanes(1, 1, 1, 1));
    idle(4);

    // Saturation on the 12-bit accumulator, then sticky clears on the next window
    drive(1, 0, 0, lanes(31, 31, 31, 31), lanes(31, 31, 31, 31));
    drive(1, 1, 0, lanes(31, 31, 31, 31), lanes(31, 31, 31, 31));
    drive(1, 1, 0, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1));
    idle(4);

    // Signed extremes
    drive(1, 1, 0, lanes(-16, -16, -16, -16), lanes(15, 15, 15, 15));
    drive(1, 1, 0, lanes(-16, -16, -16, -16), lanes(-16, -16, -16, -16));
    idle(4);

    // last without valid is ignored; the window stays open
    drive(1, 0, 0, lanes(1, 2, 3, 4), lanes(2, 2, 2, 2));
    drive(0, 1, 0, lanes(7, 7, 7, 7), lanes(7, 7, 7, 7));
    drive(1, 1, 0, lanes(1, 1, 1, 1), lanes(3, 3, 3, 3));
    idle(4);

    // Clear alongside a closing beat kills the whole window
    drive(1, 0, 0, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1));
    drive(1, 1, 1, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1));
    idle(5);
    drive(1, 1, 0, lanes(2, 2, 2, 2), lanes(1, 1, 1, 1));
    idle(4);

    // Clear in the cycle a window would emit
    drive(1, 1, 0, lanes(3, 3, 3, 3), lanes(3, 3, 3, 3));
    idle(1);
    drive(0, 0, 1, 20'd0, 20'd0);
    idle(4);

    // Async reset one cycle after a closing beat
    drive(1, 0, 0, lanes(5, 5, 5, 5), lanes(5, 5, 5, 5));
    drive(1, 1, 0, lanes(6, 6, 6, 6), lanes(6, 6, 6, 6));
    pulse_reset();
    check("rst_out_data", longint'(od0), 0);
    check("rst_out_valid", longint'(ov0), 0);
    idle(4);
    drive(1, 1, 0, lanes(5, 6, 7, 8), lanes(3, 2, 1, 4));
    idle(4);

    // Long signed window driving the 16-bit accumulator into negative clamp
    for (int k = 0; k < 40; k++)
      drive(1, k == 39, 0, lanes(-16, -16, -16, -16), lanes(15, 15, 15, 15));
    idle(4);

    // Random beats with occasional bubbles, closes and clears
    for (int k = 0; k < 60; k++) begin
      bit v, l, c;
      v = ($urandom_range(0, 3) != 0);
      l = v && ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 19) == 0);
      drive(v, l, c, 20'($urandom), 20'($urandom));
    end
    drive(1, 1, 0, lanes(1, 1, 1, 1), lanes(1, 1, 1, 1));
    idle(6);

    for (int j = 0; j < NDUT; j++)
      check($sformatf("d%0d_drain", j), longint'(exp_q[j].size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
